branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 93 +++++++++
 tb/tb_branch_target_buffer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with a one-entry-per-cycle invalidate sweep.
// Define BTB_HYST_EN to add a 2-bit confidence counter per entry that gates hits.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        hit_F,
    output logic [31:0] PredTarget_F,
    input  logic        upd_valid_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PC_T_E,
    input  logic        taken_E,
    input  logic        flush_req,
    output logic        busy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic IDLE = 1'b0;
    localparam logic FLUSH = 1'b1;

    logic               state;
    logic [IDX_W-1:0]   cnt;
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [IDX_W-1:0]   ridx, widx;
    logic [TAG_W-1:0]   rtag, wtag;
    logic               rmatch, wmatch, upd, unused;

    assign busy   = state == FLUSH;
    assign ridx   = PCF[IDX_W+1:2];
    assign rtag   = PCF[31:IDX_W+2];
    assign widx   = PCE[IDX_W+1:2];
    assign wtag   = PCE[31:IDX_W+2];
    assign rmatch = valid[ridx] && tags[ridx] == rtag;
    assign wmatch = valid[widx] && tags[widx] == wtag;
    assign upd    = upd_valid_E && !busy;
    assign unused = ^{PCF[1:0], PCE[1:0]};

`ifdef BTB_HYST_EN
    logic [1:0] ctr [ENTRIES];
    assign hit_F = !busy && rmatch && ctr[ridx][1];
`else
    assign hit_F = !busy && rmatch;
`endif
    assign PredTarget_F = hit_F ? targets[ridx] : 32'h0;

    // Payload needs no reset: it is only observable through a valid bit.
    always_ff @(posedge clk) begin
        if (upd && taken_E) begin
            tags[widx]    <= wtag;
            targets[widx] <= PC_T_E;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            state <= IDLE;
            cnt   <= '0;
`ifdef BTB_HYST_EN
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'd0;
`endif
        end else if (busy) begin
            valid[cnt] <= 1'b0;
`ifdef BTB_HYST_EN
            ctr[cnt] <= 2'd0;
`endif
            cnt <= cnt + IDX_W'(1);
            if (cnt == IDX_W'(ENTRIES - 1)) state <= IDLE;
        end else begin
            if (upd && taken_E) begin
                valid[widx] <= 1'b1;
`ifdef BTB_HYST_EN
                ctr[widx] <= !wmatch ? 2'd2 : (ctr[widx] == 2'd3 ? 2'd3 : ctr[widx] + 2'd1);
`endif
            end else if (upd && wmatch) begin
`ifdef BTB_HYST_EN
                ctr[widx] <= ctr[widx] == 2'd0 ? 2'd0 : ctr[widx] - 2'd1;
`else
                valid[widx] <= 1'b0;
`endif
            end
            // An update on the same edge lands first; the sweep then erases it.
            if (flush_req) begin
                state <= FLUSH;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed table plus hand sequences for flush, reset abort and update corners.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF;
    logic        hit_F;
    logic [31:0] PredTarget_F;
    logic        upd_valid_E;
    logic [31:0] PCE;
    logic [31:0] PC_T_E;
    logic        taken_E;
    logic        flush_req;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        upd;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic        tk;
        logic [31:0] pcf;
        logic        eh;
        logic [31:0] et;
    } vec_t;

    vec_t v [16];

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .hit_F(hit_F), .PredTarget_F(PredTarget_F),
        .upd_valid_E(upd_valid_E), .PCE(PCE), .PC_T_E(PC_T_E), .taken_E(taken_E),
        .flush_req(flush_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic u, input logic [31:0] pce, input logic [31:0] tgt, input logic tk);
        upd_valid_E = u;
        PCE = pce;
        PC_T_E = tgt;
        taken_E = tk;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic eh, input logic [31:0] et);
        PCF = pc;
        #1;
        chk({name, "_hit"}, {31'b0, hit_F}, {31'b0, eh});
        chk({name, "_tgt"}, PredTarget_F, et);
    endtask

    initial begin
        int n;
        v[0]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h100,      1'b0, 32'h0};
        v[1]  = '{1'b1, 32'h100, 32'h180,      1'b1, 32'h100,      1'b0, 32'h0};
        v[2]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h100,      1'b1, 32'h180};
        v[3]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h140,      1'b0, 32'h0};
        v[4]  = '{1'b1, 32'h200, 32'h300,      1'b1, 32'h200,      1'b0, 32'h0};
        v[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h200,      1'b1, 32'h300};
        v[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h100,      1'b0, 32'h0};
        v[7]  = '{1'b1, 32'h104, 32'h444,      1'b1, 32'h200,      1'b1, 32'h300};
        v[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h104,      1'b1, 32'h444};
        v[9]  = '{1'b1, 32'h144, 32'h0,        1'b0, 32'h104,      1'b1, 32'h444};
        v[10] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h104,      1'b1, 32'h444};
        v[11] = '{1'b1, 32'h104, 32'h0,        1'b0, 32'h104,      1'b1, 32'h444};
        v[12] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h104,      1'b0, 32'h0};
        v[13] = '{1'b1, 32'h3C,  32'hABCD0000, 1'b1, 32'h3C,       1'b0, 32'h0};
        v[14] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h3C,       1'b1, 32'hABCD0000};
        v[15] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'hFFFFFFFC, 1'b0, 32'h0};

        rst_n = 1'b0;
        PCF = 32'h100;
        flush_req = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        look("reset", 32'h100, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(v[i].upd, v[i].pce, v[i].tgt, v[i].tk);
            look($sformatf("vec%0d", i), v[i].pcf, v[i].eh, v[i].et);
            tick();
        end

        // Install, not-taken demotes to a miss, two taken restore the hit
        drive(1'b1, 32'h100, 32'h180, 1'b1);
        tick();
        drive(1'b1, 32'h100, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        look("nt_miss", 32'h100, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 32'h180, 1'b1);
        tick();
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        look("retaken", 32'h100, 1'b1, 32'h180);

        // Fill every entry, then flush with a coincident update
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        look("filled_last", 32'h3C, 1'b1, 32'h100F);
        look("filled_first", 32'h0, 1'b1, 32'h1000);
        flush_req = 1'b1;
        drive(1'b1, 32'h40, 32'h999, 1'b1);
        tick();
        flush_req = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (busy && n < 40) begin
            drive(n == 8, 32'h80, 32'h777, 1'b1);
            look($sformatf("flush_c%0d", n), (n % 2 == 0) ? 32'h40 : 32'h3C, 1'b0, 32'h0);
            n++;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("flush_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) look($sformatf("post_flush%0d", i), 32'(i * 4), 1'b0, 32'h0);
        look("post_flush_coinc", 32'h40, 1'b0, 32'h0);
        look("post_flush_mid", 32'h80, 1'b0, 32'h0);

        // Reset on flush cycle 5 aborts the sweep and clears unswept entries
        for (int i = 8; i < 12; i++) begin
            drive(1'b1, 32'(i * 4), 32'h2000 + 32'(i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        look("pre_abort", 32'h24, 1'b1, 32'h2009);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        for (int i = 8; i < 12; i++) look($sformatf("abort%0d", i), 32'(i * 4), 1'b0, 32'h0);
        tick();
        tick();
        chk("abort_busy_later", {31'b0, busy}, 32'h0);
        drive(1'b1, 32'h20, 32'h55, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        look("after_abort_upd", 32'h20, 1'b1, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
